// File: rtl/fet_pkg.sv
// Shared definitions for the nfet drain-net sampling logic.
package fet_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous reset and clear.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/drain_sampler.sv
// Waits for a slow open-drain bus to hold one fully known value for
// SETTLE_CYCLES clocks, then returns it; gives up after TIMEOUT_CYCLES.
module drain_sampler
    import fet_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    drain,
    input  logic                req,
    output logic                ready,
    output logic                valid,
    output logic [WIDTH-1:0]    data,
    output logic                timeout,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int unsigned EL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(SETTLE_CYCLES + 1);

    state_t            state, state_nx;
    logic [WIDTH-1:0]  last, last_nx, data_nx;
    logic [ST_W-1:0]   stable_cnt, stable_nx;
    logic [EL_W-1:0]   elapsed, elapsed_nx;
    logic              valid_nx, timeout_nx, glitch_inc;
    logic              known;

    always_comb begin
        known      = ((drain ^ drain) === '0);
        state_nx   = state;
        last_nx    = last;
        data_nx    = data;
        stable_nx  = stable_cnt;
        elapsed_nx = elapsed;
        valid_nx   = 1'b0;
        timeout_nx = 1'b0;
        glitch_inc = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    last_nx    = drain;
                    elapsed_nx = '0;
                    stable_nx  = known ? ST_W'(1) : '0;
                    // A one-sample window is already satisfied by a known first sample.
                    if (known && (SETTLE_CYCLES == 1)) begin
                        data_nx  = drain;
                        valid_nx = 1'b1;
                    end else begin
                        state_nx = SETTLE;
                    end
                end
            end
            SETTLE: begin
                elapsed_nx = elapsed + 1'b1;
                if (known && (drain == last)) begin
                    stable_nx = stable_cnt + 1'b1;
                end else begin
                    stable_nx  = known ? ST_W'(1) : '0;
                    last_nx    = drain;
                    glitch_inc = 1'b1;
                end
                // Settling takes priority over expiry on the same edge.
                if (stable_nx == ST_W'(SETTLE_CYCLES)) begin
                    data_nx  = last_nx;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                end else if (elapsed_nx == EL_W'(TIMEOUT_CYCLES)) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= '0;
            stable_cnt <= '0;
            elapsed    <= '0;
            data       <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            last       <= last_nx;
            stable_cnt <= stable_nx;
            elapsed    <= elapsed_nx;
            data       <= data_nx;
            valid      <= valid_nx;
            timeout    <= timeout_nx;
        end
    end

    assign ready = (state == IDLE);

    sat_counter #(
        .WIDTH(GLITCH_W)
    ) u_glitch (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (glitch_inc),
        .count (glitch_count)
    );

endmodule

// File: doc/drain_sampler.md
# drain_sampler

Clocked sampler for the open-drain nets driven by `nfet` stages. Those nets settle slowly because of RC rise and fall delays, and can briefly read as glitching or unknown. On request, the sampler watches a `WIDTH`-bit drain bus until it has held one fully known value for `SETTLE_CYCLES` consecutive clocks, then returns that value with a one-cycle valid pulse. If the bus does not settle within `TIMEOUT_CYCLES`, it reports a timeout instead. It sits directly downstream of the `nfet` drain nets and is the boundary between the analog-delay transistor models and synchronous logic and benches.

## Interface
- `WIDTH`, 8: number of drain nets sampled.
- `SETTLE_CYCLES`, 4: consecutive identical known samples required; must be ≥1.
- `TIMEOUT_CYCLES`, 64: edges allowed per request; must be > `SETTLE_CYCLES`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `drain`  in  WIDTH  open-drain nets (strong 0, weak 1; may carry x/z).
- `req`  in  1  sample request; accepted only when `ready` is high.
- `ready`  out  1  idle and able to accept `req`.
- `valid`  out  1  one-cycle pulse: `data` holds a settled value.
- `data`  out  WIDTH  last settled value; held until the next `valid`.
- `timeout`  out  1  one-cycle pulse: the request expired unsettled.
- `glitch_count`  out  8  saturating count of unstable samples since reset.

## Operation
- States: IDLE and SETTLE.
- Reset values: state IDLE, `ready`=1, `valid`=0, `timeout`=0, `data`=0, `glitch_count`=0, internal `last`/`stable_cnt`/`elapsed`=0.
- Known sample: every bit of `drain` is 0 or 1 (case-equality check; x/z is unknown).
- IDLE, `req`=1 at an edge: go to SETTLE; `last`←`drain`; `elapsed`←0. `stable_cnt`←1 if the sample is known, else 0.
- SETTLE, each edge:
  - `elapsed`←`elapsed`+1.
  - Sample known and equal to `last`: `stable_cnt`←`stable_cnt`+1.
  - Otherwise: `stable_cnt`←0 (or 1 if the new sample is known), `last`←`drain`, `glitch_count`←min(`glitch_count`+1, 255).
- Settle: when the updated `stable_cnt` reaches `SETTLE_CYCLES`: `data`←`last`, `valid`=1 next cycle, state←IDLE.
- Expiry: when `elapsed` reaches `TIMEOUT_CYCLES` without settling: `timeout`=1 next cycle, `data` unchanged, state←IDLE.
- Settle and expiry on the same edge: settle wins; `valid`=1, `timeout`=0.
- `req` while `ready`=0: ignored, not queued.
- `rst` mid-SETTLE: the request is discarded, no `valid` or `timeout`, all outputs return to reset values.
- `glitch_count` is cleared only by `rst`. It does not increment in IDLE.

## Timing
- `ready` drops the cycle after acceptance. It rises in the same cycle that `valid` or `timeout` is high, so back-to-back requests are accepted on that cycle.
- Latency with a stable, known bus: `req` accepted at edge E0 → `valid` high in the cycle after edge E0+`SETTLE_CYCLES`−1, i.e. `SETTLE_CYCLES` edges counting E0.
- Each unstable sample restarts the settle window, so latency becomes (edge of last change) + `SETTLE_CYCLES`−1.
- Timeout: `timeout` high in the cycle after edge E0+`TIMEOUT_CYCLES`.
- `valid` and `timeout` are never high together and never high for two consecutive cycles within one request.
- All outputs are registered; there is no combinational path from `drain` or `req` to any output.

## Structure
- Shared package `fet_pkg` holds:
  - the state encoding (IDLE=0, SETTLE=1);
  - the 8-bit glitch-counter width constant.
- Sub-module `sat_counter` (parameterised width, increment and clear, saturating at all-ones) implements `glitch_count`. `stable_cnt` and `elapsed` stay inline.
- Counter widths: `$clog2(TIMEOUT_CYCLES+1)` for `elapsed`, `$clog2(SETTLE_CYCLES+1)` for `stable_cnt`.

## Test plan
- Stable bus: `drain`=8'hA5 throughout, `req` pulse, defaults → `valid` after 4 edges, `data`=8'hA5, `timeout`=0, `glitch_count`=0.
- Late glitch: accept `req` with 8'h00. At 2 edges after acceptance, change to 8'h01 and hold → `valid` 4 edges after the change, `data`=8'h01, `glitch_count`=1.
- Unknown bits: `drain`=8'bzzzz_0000 for 10 cycles, then 8'h0F → no `valid` until 4 edges after the 8'h0F sample; `glitch_count` has incremented.
- Timeout: `drain` toggles 8'h00/8'hFF every cycle → `timeout` pulse exactly 64 edges after acceptance, `data` unchanged, `ready`=1 that cycle, `glitch_count` saturates at 255 after repeated requests.
- Back-to-back: assert `req` in the `valid` cycle → second request accepted, second `valid` 4 edges later; `req` while busy is ignored.
- Reset mid-SETTLE: assert `rst` 2 edges after acceptance → next cycle `ready`=1, `valid`=0, `timeout`=0, `data`=0, `glitch_count`=0, and no late pulse.
